mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-master arbiter and sequencer in front of the single-port data memory (32-bit words, base address 1024, combinational read, write on negedge).
- Master 0 is the pipeline MEM stage; master 1 is a secondary requester (debug/loader).
- Grants round-robin, holds the memory controls for a programmable number of wait cycles, returns registered read data with a one-cycle ready pulse, and rejects illegal addresses without touching memory.

Parameters:
- WAIT_CYCLES, 1, extra cycles mem_read/mem_write stay asserted beyond the first access cycle (0..15).
- BASE_ADDR, 1024, byte address of memory word 0.
- DEPTH, 256, number of 32-bit words in the memory.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- m0_req  input  1  master 0 request; held high until m0_ready.
- m0_we  input  1  master 0 write (1) / read (0).
- m0_addr  input  32  master 0 byte address.
- m0_wdata  input  32  master 0 write data.
- m0_rdata  output  32  master 0 read data, registered.
- m0_ready  output  1  master 0 one-cycle completion pulse.
- m0_err  output  1  master 0 address error, valid with m0_ready.
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ready, m1_err: same as m0_*, for master 1.
- mem_read  output  1  memory read enable.
- mem_write  output  1  memory write enable.
- mem_addr  output  32  memory byte address.
- mem_wdata  output  32  memory write data.
- mem_rdata  input  32  memory combinational read data.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0. State is IDLE, wait counter is 0, last_grant is 1, so master 0 wins the first tie.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If no req: stay in IDLE.
  - If exactly one req: grant it.
  - If both req: grant the master that is not last_grant.
  - On grant: latch id, we, addr, wdata; set last_grant to id.
  - If the address is legal: go to ACCESS with cnt = WAIT_CYCLES.
  - If the address is illegal: go directly to DONE with err flagged.
- Address legality: addr[1:0] == 0, addr >= BASE_ADDR, and addr < BASE_ADDR + 4*DEPTH. Compare in 33-bit arithmetic so overflow cannot alias.
- ACCESS:
  - mem_addr and mem_wdata are driven from the latches.
  - mem_read = !we and mem_write = we, asserted for the whole state.
  - Each edge: if cnt != 0, cnt decrements. If cnt == 0, capture mem_rdata into the granted master's rdata (reads only) and go to DONE.
  - ACCESS lasts WAIT_CYCLES+1 cycles. A repeated write of the same data on multiple negedges is harmless.
- DONE:
  - Granted master's ready = 1 for exactly one cycle.
  - err = 1 for an illegal address; for an illegal read, rdata = 0.
  - Next state is IDLE.
  - The master must drop or retarget req on the edge ending DONE. A req still high in IDLE starts a new transaction.
- Outside ACCESS: mem_read = 0 and mem_write = 0. mem_addr and mem_wdata hold their last latched values.
- rdata outputs hold their value until the next read completion for that master. The ready and err outputs of the non-granted master stay 0.
- Latency:
  - Legal transaction: ready is high in the cycle starting WAIT_CYCLES+2 edges after the edge on which req was sampled in IDLE.
  - Illegal transaction: ready is high in the cycle after the grant edge.
- Simultaneous events: req changes during ACCESS or DONE are ignored (no preemption). The losing master stays pending and is granted in the next IDLE.
- Reset mid-operation: on the rst edge the FSM returns to IDLE, ready, err and mem controls drop to 0, and the in-flight access is abandoned with no ready pulse. The memory contents already written stay as-is.

Test Plan:
- Reset: assert rst 2 cycles with m0_req=1 -> all outputs 0, busy=0. First grant after release goes to m0.
- Read, WAIT_CYCLES=1: preload word 2 = 0xDEADBEEF, m0 reads 1032 -> mem_read high 2 cycles with mem_addr=1032; m0_ready pulses once, m0_rdata=0xDEADBEEF, m0_err=0.
- Write then read, m1: write 0x12345678 to 1028, then read 1028 -> mem_write high 2 cycles; read returns 0x12345678 on m1_rdata; m0 outputs unchanged.
- Tie, both masters req continuously:
  - Grants alternate m0, m1, m0, m1.
  - Each ready pulse goes only to the granted master.
  - busy=1 except for one IDLE cycle between transactions.
- Illegal addresses: m0 reads 1020, 1026, 2048 -> each gives m0_ready with m0_err=1, m0_rdata=0, one cycle after the grant edge. mem_read/mem_write never assert.
- Reset mid-ACCESS: m0 write in flight, rst asserted in the second ACCESS cycle -> mem_write=0 and no m0_ready. The next req completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter and sequencer for the single-port data memory.
// One transaction at a time: IDLE grants, ACCESS drives the memory, DONE pulses ready.
module mem_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int BASE_ADDR   = 1024,
    parameter int DEPTH       = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    output logic        m1_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // 33-bit bounds so an address near 2^32 cannot wrap into the legal window
    localparam logic [32:0] ADDR_LO = 33'(BASE_ADDR);
    localparam logic [32:0] ADDR_HI = 33'(BASE_ADDR) + 33'(4 * DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES);

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic        last_grant;
    logic        gid;
    logic        gwe;
    logic        gerr;
    logic [31:0] gaddr;
    logic [31:0] gwdata;

    logic        grant_valid;
    logic        grant_id;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        addr_ok;

    always_comb begin
        grant_valid = m0_req | m1_req;
        if (m0_req && m1_req) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = m1_req;
        end
        sel_we    = grant_id ? m1_we    : m0_we;
        sel_addr  = grant_id ? m1_addr  : m0_addr;
        sel_wdata = grant_id ? m1_wdata : m0_wdata;
        addr_ok   = (sel_addr[1:0] == 2'b00) &&
                    ({1'b0, sel_addr} >= ADDR_LO) &&
                    ({1'b0, sel_addr} <  ADDR_HI);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_next = addr_ok ? ACCESS : DONE;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= 4'd0;
            last_grant <= 1'b1;
            gid        <= 1'b0;
            gwe        <= 1'b0;
            gerr       <= 1'b0;
            gaddr      <= 32'd0;
            gwdata     <= 32'd0;
            m0_rdata   <= 32'd0;
            m1_rdata   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        gid        <= grant_id;
                        last_grant <= grant_id;
                        gwe        <= sel_we;
                        gaddr      <= sel_addr;
                        gwdata     <= sel_wdata;
                        gerr       <= ~addr_ok;
                        cnt        <= CNT_INIT;
                        // A rejected read returns zero data alongside the error
                        if (!addr_ok && !sel_we) begin
                            if (grant_id) m1_rdata <= 32'd0;
                            else          m0_rdata <= 32'd0;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else if (!gwe) begin
                        if (gid) m1_rdata <= mem_rdata;
                        else     m0_rdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_read  = (state == ACCESS) && !gwe;
        mem_write = (state == ACCESS) &&  gwe;
        mem_addr  = gaddr;
        mem_wdata = gwdata;
        m0_ready  = (state == DONE) && !gid;
        m1_ready  = (state == DONE) &&  gid;
        m0_err    = (state == DONE) && !gid && gerr;
        m1_err    = (state == DONE) &&  gid && gerr;
        busy      = (state != IDLE);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a behavioural memory on the bus, directed and random
// transactions, and a transaction-level model predicting grant order and results.
module tb_mem_arbiter;

    localparam int W     = 1;
    localparam int BASE  = 1024;
    localparam int DEPTH = 256;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ready, m0_err, m1_ready, m1_err;
    logic        mem_read, mem_write, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.WAIT_CYCLES(W), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory on the bus: cleared on the first negedge, then written on negedge
    logic [31:0] mem [DEPTH];
    logic        mem_inited = 1'b0;

    function automatic bit legal(input logic [31:0] a);
        longint la;
        la = longint'(a);
        return (la % 4 == 0) && (la >= BASE) && (la < BASE + 4 * DEPTH);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - 32'(BASE)) >> 2);
    endfunction

    always @(negedge clk) begin
        if (!mem_inited) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
            mem_inited <= 1'b1;
        end else if (mem_write && legal(mem_addr)) begin
            mem[widx(mem_addr)] <= mem_wdata;
        end
    end

    always_comb begin
        mem_rdata = 32'h0;
        if (legal(mem_addr)) mem_rdata = mem[widx(mem_addr)];
    end

    // Reference model state
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] exp_rdata [2];
    int          ref_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int id, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
        if (id == 0) begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int k;
        if ($urandom_range(0, 4) == 0) begin
            k = $urandom_range(0, 3);
            case (k)
                0:       return 32'(BASE - 4);
                1:       return 32'(BASE + 4 * DEPTH);
                2:       return 32'(BASE + 4 * $urandom_range(0, 15) + $urandom_range(1, 3));
                default: return 32'hFFFF_FFFC;
            endcase
        end
        return 32'(BASE + 4 * $urandom_range(0, 15));
    endfunction

    task automatic check_quiet(input string tag);
        chk({tag, "_mem_read"},  mem_read,  0);
        chk({tag, "_mem_write"}, mem_write, 0);
        chk({tag, "_m0_ready"},  m0_ready,  0);
        chk({tag, "_m1_ready"},  m1_ready,  0);
        chk({tag, "_m0_err"},    m0_err,    0);
        chk({tag, "_m1_err"},    m1_err,    0);
        chk({tag, "_busy"},      busy,      0);
    endtask

    // Runs one transaction from an IDLE cycle whose requests are already driven;
    // the model picks the winner, and the winner's request is dropped in DONE.
    task automatic run_txn(output int winner);
        int          pred, n, rd_c, wr_c;
        logic        we, rdy;
        logic [31:0] addr, wdata;
        bit          ok;
        pred  = (m0_req && m1_req) ? 1 - ref_last : (m1_req ? 1 : 0);
        we    = (pred == 1) ? m1_we    : m0_we;
        addr  = (pred == 1) ? m1_addr  : m0_addr;
        wdata = (pred == 1) ? m1_wdata : m0_wdata;
        ok    = legal(addr);
        n = 0; rd_c = 0; wr_c = 0; rdy = 1'b0;
        while (!rdy && n < 40) begin
            tick();
            n++;
            rdy = (pred == 1) ? m1_ready : m0_ready;
            if (!rdy) begin
                rd_c += int'(mem_read);
                wr_c += int'(mem_write);
                if (mem_read || mem_write) chk("mem_addr", mem_addr, addr);
                if (mem_write) chk("mem_wdata", mem_wdata, wdata);
                chk("busy_access", busy, 1);
                chk("other_ready_access", (pred == 1) ? m0_ready : m1_ready, 0);
            end
        end
        chk("ready", rdy, 1);
        chk("latency", 32'(n), ok ? 32'(W + 2) : 32'd1);
        chk("read_cycles",  32'(rd_c), (ok && !we) ? 32'(W + 1) : 32'd0);
        chk("write_cycles", 32'(wr_c), (ok &&  we) ? 32'(W + 1) : 32'd0);
        if (ok && we) ref_mem[widx(addr)] = wdata;
        if (!we) exp_rdata[pred] = ok ? ref_mem[widx(addr)] : 32'd0;
        ref_last = pred;
        chk("err", (pred == 1) ? m1_err : m0_err, 32'(!ok));
        chk("other_ready", (pred == 1) ? m0_ready : m1_ready, 0);
        chk("other_err",   (pred == 1) ? m0_err   : m1_err,   0);
        chk("m0_rdata", m0_rdata, exp_rdata[0]);
        chk("m1_rdata", m1_rdata, exp_rdata[1]);
        chk("busy_done", busy, 1);
        if (pred == 1) m1_req = 1'b0;
        else           m0_req = 1'b0;
        winner = pred;
    endtask

    task automatic idle_gap();
        tick();
        chk("gap_busy", busy, 0);
        chk("gap_m0_ready", m0_ready, 0);
        chk("gap_m1_ready", m1_ready, 0);
    endtask

    initial begin
        int          w;
        logic [31:0] d;
        logic [31:0] ill [4];
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
        exp_rdata[0] = 32'd0;
        exp_rdata[1] = 32'd0;
        ref_last = 1;
        ill[0] = 32'd1020; ill[1] = 32'd1026; ill[2] = 32'd2048; ill[3] = 32'hFFFF_FFFC;

        // Reset with both masters requesting; m0 must win first, m1 stays pending
        rst = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0;
        drive(0, 1'b0, 32'd1024, 32'd0);
        drive(1, 1'b1, 32'd1036, 32'hA5A5_0001);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_quiet("reset");
            chk("reset_mem_addr",  mem_addr,  0);
            chk("reset_mem_wdata", mem_wdata, 0);
            chk("reset_m0_rdata",  m0_rdata,  0);
            chk("reset_m1_rdata",  m1_rdata,  0);
        end
        rst = 1'b0;
        run_txn(w);
        chk("first_grant_m0", 32'(w), 0);
        idle_gap();
        run_txn(w);
        chk("pending_grant_m1", 32'(w), 1);
        idle_gap();

        // Preload word 2 via m1, then m0 reads it back
        drive(1, 1'b1, 32'd1032, 32'hDEAD_BEEF);
        run_txn(w);
        idle_gap();
        drive(0, 1'b0, 32'd1032, 32'd0);
        run_txn(w);
        idle_gap();
        chk("m0_read_deadbeef", m0_rdata, 32'hDEAD_BEEF);

        // m1 write then read of 1028
        drive(1, 1'b1, 32'd1028, 32'h1234_5678);
        run_txn(w);
        idle_gap();
        drive(1, 1'b0, 32'd1028, 32'd0);
        run_txn(w);
        idle_gap();
        chk("m1_read_12345678", m1_rdata, 32'h1234_5678);

        // Both masters request continuously; the winner retargets in DONE
        drive(0, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
        drive(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
        for (int i = 0; i < 8; i++) begin
            run_txn(w);
            chk("tie_alternate", 32'(w), 32'(i % 2));
            drive(w, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
            idle_gap();
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();

        // Illegal addresses from m0
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b0, ill[i], 32'd0);
            run_txn(w);
            chk("illegal_rdata_zero", m0_rdata, 0);
            idle_gap();
        end

        // Reset during the second ACCESS cycle of an m0 write
        d = $urandom;
        drive(0, 1'b1, 32'd1040, d);
        tick();
        chk("midrst_write_c1", mem_write, 1);
        tick();
        chk("midrst_write_c2", mem_write, 1);
        rst = 1'b1;
        m0_req = 1'b0;
        tick();
        check_quiet("midrst");
        rst = 1'b0;
        ref_mem[widx(32'd1040)] = d;
        exp_rdata[0] = 32'd0;
        exp_rdata[1] = 32'd0;
        ref_last = 1;
        drive(0, 1'b0, 32'd1040, 32'd0);
        run_txn(w);
        chk("after_rst_grant", 32'(w), 0);
        chk("after_rst_read", m0_rdata, d);
        idle_gap();

        // Random request patterns
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 2))
                0: drive(0, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
                1: drive(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
                default: begin
                    drive(0, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
                    drive(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
                end
            endcase
            while (m0_req || m1_req) begin
                run_txn(w);
                idle_gap();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
